// File: rtl/fpu_mult_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP multiplier core among N_REQ requesters,
// with a watchdog that answers with a quiet NaN if the core never reports done.
module fpu_mult_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [32*N_REQ-1:0]   req_a,
   input  logic [32*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_result,
   output logic [2:0]            rsp_ovf,
   output logic                  rsp_err,
   output logic                  busy,
   output logic [31:0]           mul_a,
   output logic [31:0]           mul_b,
   output logic                  mul_start,
   input  logic                  mul_done,
   input  logic [31:0]           mul_result,
   input  logic [2:0]            mul_ovf
);

   localparam int               CNT_W     = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(N_REQ - 1);
   localparam logic [31:0]      QNAN      = 32'h7FC0_0000;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state;
   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   grant;
   logic [ID_W-1:0]   idx;
   logic              any_valid;
   logic [31:0]       sel_a;
   logic [31:0]       sel_b;
   logic [CNT_W-1:0]  wdog;

   // Search starts just after the last granted requester and wraps modulo N_REQ.
   always_comb begin
      any_valid = 1'b0;
      grant     = '0;
      idx       = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = ID_W'((32'(last_grant) + k) % N_REQ);
         if (!any_valid && req_valid[idx]) begin
            any_valid = 1'b1;
            grant     = idx;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant == ID_W'(i)) begin
            sel_a = req_a[32*i +: 32];
            sel_b = req_b[32*i +: 32];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && any_valid && !rst) begin
         for (int unsigned i = 0; i < N_REQ; i++)
            req_ready[i] = (grant == ID_W'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= LAST_INIT;
         wdog       <= '0;
         mul_a      <= '0;
         mul_b      <= '0;
         mul_start  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_ovf    <= '0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  mul_a     <= sel_a;
                  mul_b     <= sel_b;
                  rsp_id    <= grant;
                  mul_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               mul_start <= 1'b0;
               wdog      <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               // A done arriving on the timeout cycle takes priority over the error.
               if (mul_done) begin
                  rsp_result <= mul_result;
                  rsp_ovf    <= mul_ovf;
                  rsp_err    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (wdog == CNT_LAST) begin
                  rsp_result <= QNAN;
                  rsp_ovf    <= '0;
                  rsp_err    <= 1'b1;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (wdog != '1) begin
                  wdog <= wdog + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid  <= 1'b0;
                  busy       <= 1'b0;
                  last_grant <= rsp_id;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// Bench for fpu_mult_arbiter: stub multiplier core, directed vector table,
// hand-written reset/latency sequences and a randomized round-robin model.
module tb_fpu_mult_arbiter;

   localparam int N   = 4;
   localparam int TMO = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [32*N-1:0] req_a, req_b;
   logic [N-1:0]   req_ready;
   logic           rsp_valid, rsp_ready;
   logic [1:0]     rsp_id;
   logic [31:0]    rsp_result;
   logic [2:0]     rsp_ovf;
   logic           rsp_err, busy;
   logic [31:0]    mul_a, mul_b;
   logic           mul_start;
   logic           mul_done = 1'b0;
   logic [31:0]    mul_result = '0;
   logic [2:0]     mul_ovf = '0;

   // stub core controls
   int          stub_lat   = 3;
   bit          stub_never = 0;
   bit          stub_fixed = 0;
   logic [31:0] stub_res   = '0;
   logic [2:0]  stub_ovfv  = '0;
   bit          force_done = 0;
   int          stub_cnt   = 0;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   int mlast = N - 1;

   fpu_mult_arbiter #(.N_REQ(N), .ID_W(2), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
      .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
      .mul_done(mul_done), .mul_result(mul_result), .mul_ovf(mul_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] stub_f(input logic [31:0] a, input logic [31:0] b);
      return a ^ {b[15:0], b[31:16]};
   endfunction
   function automatic logic [2:0] stub_o(input logic [31:0] a, input logic [31:0] b);
      return a[2:0] ^ b[2:0];
   endfunction

   // Core stub: mul_done pulses stub_lat cycles after the cycle mul_start is high.
   always @(posedge clk) begin
      mul_done <= force_done;
      if (mul_start && !stub_never) begin
         stub_cnt <= stub_lat - 1;
      end else if (stub_cnt > 0) begin
         if (stub_cnt == 1) begin
            mul_done   <= 1'b1;
            mul_result <= stub_fixed ? stub_res  : stub_f(mul_a, mul_b);
            mul_ovf    <= stub_fixed ? stub_ovfv : stub_o(mul_a, mul_b);
         end
         stub_cnt <= stub_cnt - 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_grant(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_rsp_ovf_err", {rsp_ovf, rsp_err}, 0);
      check("rst_busy_start", {busy, mul_start}, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_mul_b", mul_b, 0);
      check("rst_req_ready", req_ready, 0);
      @(negedge clk);
      rst = 1'b0; mlast = N - 1;
      #1;
   endtask

   // Wait for the accept of requester id, follow it through the core and the response.
   task automatic serve(input int id, input logic [31:0] eres, input logic [2:0] eovf,
                        input logic eerr, input int hold, input bit drop, input int elat);
      int w, c0;
      logic [31:0] ea, eb;
      w = 0;
      while (req_ready == '0 && w < 30) begin @(negedge clk); #1; w++; end
      check("accept_onehot", 32'(req_ready), 32'(1 << id));
      c0 = cyc;
      ea = req_a[32*id +: 32];
      eb = req_b[32*id +: 32];
      @(negedge clk);
      if (drop) req_valid[id] = 1'b0;
      #1;
      check("mul_start", mul_start, 1);
      check("mul_a", mul_a, ea);
      check("mul_b", mul_b, eb);
      w = 0;
      while (!rsp_valid && w < 30) begin @(negedge clk); #1; w++; end
      check("rsp_valid", rsp_valid, 1);
      if (elat >= 0) check("latency", cyc - c0, elat);
      check("rsp_id", rsp_id, id);
      check("rsp_result", rsp_result, eres);
      check("rsp_ovf_err", {rsp_ovf, rsp_err}, {eovf, eerr});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk); #1;
         check("hold_valid", rsp_valid, 1);
         check("hold_fields", {rsp_id, rsp_ovf, rsp_err}, {2'(id), eovf, eerr});
         check("hold_result", rsp_result, eres);
         check("hold_no_accept", req_ready, 0);
      end
      @(negedge clk); rsp_ready = 1'b1; #1;
      check("hs_valid", rsp_valid, 1);
      @(negedge clk); rsp_ready = 1'b0; #1;
      check("rsp_drop", {rsp_valid, busy}, 0);
      mlast = id;
   endtask

   typedef struct {
      int          id;
      int          lat;
      bit          never;
      bit          fixed;
      logic [31:0] res;
      logic [2:0]  ovf;
      int          hold;
   } vec_t;

   vec_t vt[11];

   initial begin
      logic [31:0] er;
      logic [2:0]  eo;
      int g;
      #1_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [31:0] er;
      logic [2:0]  eo;
      int g;
      vt[0]  = '{0, 3, 0, 0, 32'h0, 3'h0, 0};
      vt[1]  = '{1, 3, 0, 0, 32'h0, 3'h0, 0};
      vt[2]  = '{2, 4, 0, 0, 32'h0, 3'h0, 0};
      vt[3]  = '{3, 2, 0, 0, 32'h0, 3'h0, 0};
      vt[4]  = '{0, 3, 0, 0, 32'h0, 3'h0, 0};
      vt[5]  = '{1, 3, 0, 0, 32'h0, 3'h0, 5};            // backpressure
      vt[6]  = '{2, 3, 0, 0, 32'h0, 3'h0, 0};
      vt[7]  = '{3, 3, 1, 0, 32'h0, 3'h0, 2};            // watchdog timeout
      vt[8]  = '{0, 3, 0, 0, 32'h0, 3'h0, 0};
      vt[9]  = '{1, 5, 0, 1, 32'h7F7FFFFE, 3'b001, 0};   // overflow flags pass through
      vt[10] = '{2, TMO, 0, 0, 32'h0, 3'h0, 0};          // done on the timeout cycle

      rst = 1'b0; req_valid = '0; rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_a[32*i +: 32] = $urandom;
         req_b[32*i +: 32] = $urandom;
      end
      do_reset();

      // single op, core latency 3
      req_a[64 +: 32] = 32'h40000000;
      req_b[64 +: 32] = 32'h40400000;
      stub_fixed = 1; stub_res = 32'h40C00000; stub_ovfv = '0; stub_lat = 3;
      req_valid = 4'b0100; #1;
      serve(2, 32'h40C00000, 3'b000, 1'b0, 0, 1, 5);

      // all requesters continuously valid
      do_reset();
      req_valid = '1; #1;
      for (int r = 0; r < 11; r++) begin
         stub_lat = vt[r].lat; stub_never = vt[r].never; stub_fixed = vt[r].fixed;
         stub_res = vt[r].res; stub_ovfv = vt[r].ovf;
         if (vt[r].never) begin er = 32'h7FC00000; eo = '0; end
         else if (vt[r].fixed) begin er = vt[r].res; eo = vt[r].ovf; end
         else begin
            er = stub_f(req_a[32*vt[r].id +: 32], req_b[32*vt[r].id +: 32]);
            eo = stub_o(req_a[32*vt[r].id +: 32], req_b[32*vt[r].id +: 32]);
         end
         serve(vt[r].id, er, eo, vt[r].never, vt[r].hold, 0,
               vt[r].never ? TMO + 2 : vt[r].lat + 2);
      end
      stub_never = 0; stub_fixed = 0;

      // reset while waiting on the core, then a stale done
      req_valid = '0;
      @(negedge clk); req_valid = 4'b0010; #1;
      check("t5_accept", req_ready, 4'b0010);
      stub_never = 1;
      @(negedge clk); req_valid = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1; #1;
      check("t5_rst_state", {rsp_valid, busy, mul_start, rsp_err}, 0);
      check("t5_rst_mul_a", mul_a, 0);
      check("t5_rst_result", rsp_result, 0);
      check("t5_rst_id", rsp_id, 0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      @(negedge clk); force_done = 1;
      @(negedge clk); force_done = 0;
      @(negedge clk); #1;
      check("t5_stale_done", {rsp_valid, busy, mul_start}, 0);
      stub_never = 0; stub_lat = 3; mlast = N - 1;
      req_valid = '1; #1;
      serve(0, stub_f(req_a[31:0], req_b[31:0]), stub_o(req_a[31:0], req_b[31:0]), 0, 0, 1, 5);

      // randomized traffic against the round-robin model
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               req_valid[i] = 1'b1;
               req_a[32*i +: 32] = $urandom;
               req_b[32*i +: 32] = $urandom;
            end
         end
         if (req_valid == '0) begin
            g = $urandom_range(0, N - 1);
            req_valid[g] = 1'b1;
            req_a[32*g +: 32] = $urandom;
            req_b[32*g +: 32] = $urandom;
         end
         stub_lat = $urandom_range(2, TMO);
         stub_never = ($urandom_range(0, 7) == 0);
         #1;
         g = exp_grant(req_valid, mlast);
         if (stub_never) begin er = 32'h7FC00000; eo = '0; end
         else begin
            er = stub_f(req_a[32*g +: 32], req_b[32*g +: 32]);
            eo = stub_o(req_a[32*g +: 32], req_b[32*g +: 32]);
         end
         serve(g, er, eo, stub_never, $urandom_range(0, 3), 1,
               stub_never ? TMO + 2 : stub_lat + 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
